// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the registered immediate generator: format codes,
// opcodes, buffer state encoding and the opcode/funct3 format decoder.
package imm_pkg;

    localparam logic [2:0] FMT_I       = 3'b000;
    localparam logic [2:0] FMT_S       = 3'b001;
    localparam logic [2:0] FMT_B       = 3'b010;
    localparam logic [2:0] FMT_J       = 3'b011;
    localparam logic [2:0] FMT_U       = 3'b100;
    localparam logic [2:0] FMT_SHAMT   = 3'b101;
    localparam logic [2:0] FMT_NONE    = 3'b110;
    localparam logic [2:0] FMT_ILLEGAL = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    // Shift-immediate ops are the OP-IMM encodings with funct3 001/101.
    function automatic logic [2:0] decode_fmt(input logic [6:0] opcode, input logic [2:0] funct3);
        logic [2:0] fmt_v;
        case (opcode)
            OP_LOAD, OP_JALR, OP_SYSTEM: fmt_v = FMT_I;
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) fmt_v = FMT_SHAMT;
                else                                      fmt_v = FMT_I;
            end
            OP_STORE:        fmt_v = FMT_S;
            OP_BRANCH:       fmt_v = FMT_B;
            OP_JAL:          fmt_v = FMT_J;
            OP_LUI, OP_AUIPC: fmt_v = FMT_U;
            OP_REG:          fmt_v = FMT_NONE;
            default:         fmt_v = FMT_ILLEGAL;
        endcase
        return fmt_v;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bus of the immediate generator: instruction input side and
// extended-immediate output side.
interface imm_gen_pipe_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_ins;
    logic [2:0]      in_sel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [31:0]     out_ins;

    modport master (
        output in_valid, in_ins, in_sel, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_ins
    );

    modport slave (
        input  in_valid, in_ins, in_sel, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_ins
    );
endinterface

// File: rtl/imm_gen_pipe_extend.sv
// Combinational immediate extender: builds the XLEN-wide immediate for a
// given format and flags encodings that cannot be represented.
module imm_extend
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     ins,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Format-dependent bit scatter; U uses XLEN-31 copies of bit 31 so XLEN=32 never needs a zero replication.
    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_I: imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
            FMT_S: imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B: imm = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_J: imm = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            FMT_U: imm = {{(XLEN-31){ins[31]}}, ins[30:12], 12'h000};
            FMT_SHAMT: begin
                if (XLEN == 32) begin
                    if (ins[25]) begin
                        illegal = 1'b1;
                        imm     = '0;
                    end else begin
                        imm = {{(XLEN-5){1'b0}}, ins[24:20]};
                    end
                end else begin
                    imm = {{(XLEN-6){1'b0}}, ins[25:20]};
                end
            end
            FMT_NONE:    imm = '0;
            FMT_ILLEGAL: illegal = 1'b1;
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked immediate generator with a two-entry skid buffer
// (main register drives the outputs, skid register absorbs one extra word).
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    state_e          state_r, state_next_s;
    logic            out_valid_r, in_ready_r;
    logic            accept_s, pop_s;
    logic            load_m_in_s, load_m_k_s, load_k_s;
    logic [2:0]      sel_fmt_s, new_fmt_s;
    logic [XLEN-1:0] ext_imm_s;
    logic            ext_illegal_s;
    logic [XLEN-1:0] m_imm_r, k_imm_r;
    logic [2:0]      m_fmt_r, k_fmt_r;
    logic            m_ill_r, k_ill_r;
    logic [31:0]     m_ins_r, k_ins_r;

    assign accept_s = bus.in_valid & in_ready_r;
    assign pop_s    = out_valid_r & bus.out_ready;

    // Format selection ahead of the buffer registers.
    always_comb begin
        if (AUTO_DECODE != 0) sel_fmt_s = decode_fmt(bus.in_ins[6:0], bus.in_ins[14:12]);
        else                  sel_fmt_s = bus.in_sel;
    end

    imm_extend #(.XLEN(XLEN)) u_extend (
        .ins     (bus.in_ins[31:7]),
        .fmt     (sel_fmt_s),
        .imm     (ext_imm_s),
        .illegal (ext_illegal_s)
    );

    assign new_fmt_s = ext_illegal_s ? FMT_ILLEGAL : sel_fmt_s;

    // Next-state logic; flush overrides every accept/pop.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) state_next_s = ST_ONE;
                    else          state_next_s = ST_EMPTY;
                end
                ST_ONE: begin
                    if (accept_s && !pop_s)      state_next_s = ST_FULL;
                    else if (pop_s && !accept_s) state_next_s = ST_EMPTY;
                    else                         state_next_s = ST_ONE;
                end
                ST_FULL: begin
                    if (pop_s) state_next_s = ST_ONE;
                    else       state_next_s = ST_FULL;
                end
                default: state_next_s = ST_EMPTY;
            endcase
        end
    end

    // Register load controls derived from the current state and handshakes.
    always_comb begin
        load_m_in_s = 1'b0;
        load_m_k_s  = 1'b0;
        load_k_s    = 1'b0;
        if (flush) begin
            load_m_in_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: load_m_in_s = accept_s;
                ST_ONE: begin
                    load_m_in_s = accept_s & pop_s;
                    load_k_s    = accept_s & ~pop_s;
                end
                ST_FULL:  load_m_k_s = pop_s;
                default:  load_m_in_s = 1'b0;
            endcase
        end
    end

    // State register; in_ready and out_valid are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s != ST_EMPTY);
            in_ready_r  <= (state_next_s != ST_FULL);
        end
    end

    // Main and skid data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_imm_r <= '0;
            m_fmt_r <= FMT_I;
            m_ill_r <= 1'b0;
            m_ins_r <= 32'h0000_0000;
            k_imm_r <= '0;
            k_fmt_r <= FMT_I;
            k_ill_r <= 1'b0;
            k_ins_r <= 32'h0000_0000;
        end else begin
            if (load_m_in_s) begin
                m_imm_r <= ext_imm_s;
                m_fmt_r <= new_fmt_s;
                m_ill_r <= ext_illegal_s;
                m_ins_r <= bus.in_ins;
            end else if (load_m_k_s) begin
                m_imm_r <= k_imm_r;
                m_fmt_r <= k_fmt_r;
                m_ill_r <= k_ill_r;
                m_ins_r <= k_ins_r;
            end
            if (load_k_s) begin
                k_imm_r <= ext_imm_s;
                k_fmt_r <= new_fmt_s;
                k_ill_r <= ext_illegal_s;
                k_ins_r <= bus.in_ins;
            end
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_imm     = m_imm_r;
    assign bus.out_fmt     = m_fmt_r;
    assign bus.out_illegal = m_ill_r;
    assign bus.out_ins     = m_ins_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN 32/64 auto-decode, XLEN 32
// external select) share one stimulus stream and a queue-based reference model.
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  sel;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_ins = 32'h0;
    logic [2:0]  in_sel = 3'b000;
    logic        out_ready = 1'b0;

    int     n_cmp = 0;
    int     n_bad = 0;
    bit     armed = 1'b0;
    entry_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();
    imm_gen_pipe_if #(.XLEN(32)) bm ();

    assign b32.in_valid = in_valid;  assign b32.in_ins = in_ins;
    assign b32.in_sel   = in_sel;    assign b32.out_ready = out_ready;
    assign b64.in_valid = in_valid;  assign b64.in_ins = in_ins;
    assign b64.in_sel   = in_sel;    assign b64.out_ready = out_ready;
    assign bm.in_valid  = in_valid;  assign bm.in_ins  = in_ins;
    assign bm.in_sel    = in_sel;    assign bm.out_ready  = out_ready;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1)) d32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1)) d64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));
    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0)) dm  (.clk(clk), .rst(rst), .flush(flush), .bus(bm));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_fmt(input logic [31:0] ins, input logic [2:0] sel,
                                           input bit auto, input int xlen);
        logic [2:0] f;
        if (auto) begin
            case (ins[6:0])
                7'h03, 7'h67, 7'h73: f = 3'd0;
                7'h13:   f = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? 3'd5 : 3'd0;
                7'h23:   f = 3'd1;
                7'h63:   f = 3'd2;
                7'h6F:   f = 3'd3;
                7'h37, 7'h17: f = 3'd4;
                7'h33:   f = 3'd6;
                default: f = 3'd7;
            endcase
        end else begin
            f = sel;
        end
        if (f == 3'd5 && xlen == 32 && ins[25]) f = 3'd7;
        return f;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] f, input int xlen);
        longint s, r;
        s = longint'($signed(ins));
        case (f)
            3'd0: r = s >>> 20;
            3'd1: r = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
            3'd2: r = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                      | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            3'd3: r = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                      | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            3'd4: r = (s >>> 12) <<< 12;
            3'd5: r = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: r = 0;
        endcase
        if (xlen == 32) return {32'h0, r[31:0]};
        return r;
    endfunction

    task automatic chk_inst(input string tag, input int xlen, input bit auto,
                            input logic rdy, input logic vld, input logic [63:0] imm,
                            input logic [2:0] fmt, input logic ill, input logic [31:0] ins);
        logic [2:0] f;
        check_val({tag, ".in_ready"}, 64'(rdy), 64'(armed && q.size() < 2));
        check_val({tag, ".out_valid"}, 64'(vld), 64'(q.size() > 0));
        if (q.size() > 0) begin
            f = ref_fmt(q[0].ins, q[0].sel, auto, xlen);
            check_val({tag, ".out_fmt"}, 64'(fmt), 64'(f));
            check_val({tag, ".out_illegal"}, 64'(ill), 64'(f == 3'd7));
            check_val({tag, ".out_imm"}, imm, ref_imm(q[0].ins, f, xlen));
            check_val({tag, ".out_ins"}, 64'(ins), 64'(q[0].ins));
        end
    endtask

    task automatic check_model();
        chk_inst("x32", 32, 1'b1, b32.in_ready, b32.out_valid, 64'(b32.out_imm),
                 b32.out_fmt, b32.out_illegal, b32.out_ins);
        chk_inst("x64", 64, 1'b1, b64.in_ready, b64.out_valid, b64.out_imm,
                 b64.out_fmt, b64.out_illegal, b64.out_ins);
        chk_inst("sel", 32, 1'b0, bm.in_ready, bm.out_valid, 64'(bm.out_imm),
                 bm.out_fmt, bm.out_illegal, bm.out_ins);
    endtask

    // One clock: drive at edge+1, check at the falling edge, update the model at the rising edge.
    task automatic step(input bit v, input logic [31:0] ins, input logic [2:0] sel,
                        input bit ordy, input bit fl);
        bit acc, pop;
        entry_t e;
        in_valid = v; in_ins = ins; in_sel = sel; out_ready = ordy; flush = fl;
        @(negedge clk);
        check_model();
        acc = v && armed && (q.size() < 2);
        pop = (q.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.ins = ins; e.sel = sel;
                q.push_back(e);
            end
        end
        armed = 1'b1;
        #1;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0]  ops [11];
        logic [31:0] r;
        ops = '{7'h03, 7'h67, 7'h73, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h13};
        r = $urandom();
        if ($urandom_range(0, 7) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 10)]};
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst.x32.valid", 64'(b32.out_valid), 64'h0);
        check_val("rst.x64.imm", b64.out_imm, 64'h0);
        check_val("rst.x32.fmt", 64'(b32.out_fmt), 64'h0);
        check_val("rst.x32.illegal", 64'(b32.out_illegal), 64'h0);
        check_val("rst.x32.ins", 64'(b32.out_ins), 64'h0);
        check_val("rst.x32.in_ready", 64'(b32.in_ready), 64'h0);
        rst = 1'b0;
        armed = 1'b0;
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        check_val("post_rst.in_ready", 64'(b32.in_ready), 64'h1);

        // Directed vectors, out_ready held high
        step(1'b1, 32'hFFF00093, 3'd0, 1'b1, 1'b0);
        check_val("addi.valid", 64'(b32.out_valid), 64'h1);
        check_val("addi.imm", 64'(b32.out_imm), 64'hFFFFFFFF);
        check_val("addi.fmt", 64'(b32.out_fmt), 64'h0);
        check_val("addi.illegal", 64'(b32.out_illegal), 64'h0);
        step(1'b1, 32'hFE112E23, 3'd1, 1'b1, 1'b0);
        check_val("sw.imm", 64'(b32.out_imm), 64'hFFFFFFFC);
        check_val("sw.fmt", 64'(b32.out_fmt), 64'h1);
        step(1'b1, 32'hFE000CE3, 3'd2, 1'b1, 1'b0);
        check_val("beq.imm", 64'(b32.out_imm), 64'hFFFFFFF8);
        check_val("beq.fmt", 64'(b32.out_fmt), 64'h2);
        step(1'b1, 32'h800002B7, 3'd4, 1'b1, 1'b0);
        check_val("lui64.imm", b64.out_imm, 64'hFFFFFFFF80000000);
        step(1'b1, 32'h02009093, 3'd5, 1'b1, 1'b0);
        check_val("slli64.imm", b64.out_imm, 64'd32);
        check_val("slli64.fmt", 64'(b64.out_fmt), 64'h5);
        check_val("slli32.illegal", 64'(b32.out_illegal), 64'h1);
        check_val("slli32.imm", 64'(b32.out_imm), 64'h0);
        check_val("slli32.sel.illegal", 64'(bm.out_illegal), 64'h1);
        step(1'b1, 32'h0000007F, 3'd7, 1'b1, 1'b0);
        check_val("op7f.fmt", 64'(b32.out_fmt), 64'h7);
        check_val("op7f.illegal", 64'(b32.out_illegal), 64'h1);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

        // Backpressure: A,B fill the buffer, C waits until space opens
        step(1'b1, 32'h00A00013, 3'd0, 1'b0, 1'b0);
        step(1'b1, 32'h00B00013, 3'd0, 1'b0, 1'b0);
        check_val("bp.full.in_ready", 64'(b32.in_ready), 64'h0);
        step(1'b1, 32'h00C00013, 3'd0, 1'b0, 1'b0);
        check_val("bp.stable.A", 64'(b32.out_ins), 64'h00A00013);
        step(1'b1, 32'h00C00013, 3'd0, 1'b1, 1'b0);
        check_val("bp.order.B", 64'(b32.out_ins), 64'h00B00013);
        step(1'b1, 32'h00C00013, 3'd0, 1'b1, 1'b0);
        check_val("bp.order.C", 64'(b32.out_ins), 64'h00C00013);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        check_val("bp.drained", 64'(b32.out_valid), 64'h0);

        // Flush while full with a word offered
        step(1'b1, 32'h11100013, 3'd0, 1'b0, 1'b0);
        step(1'b1, 32'h22200013, 3'd0, 1'b0, 1'b0);
        step(1'b1, 32'h33300013, 3'd0, 1'b0, 1'b1);
        check_val("flush.valid", 64'(b32.out_valid), 64'h0);
        check_val("flush.in_ready", 64'(b32.in_ready), 64'h1);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a full cycle
        step(1'b1, 32'h44400013, 3'd0, 1'b0, 1'b0);
        step(1'b1, 32'h55500013, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst.x32.valid", 64'(b32.out_valid), 64'h0);
        check_val("arst.x64.valid", 64'(b64.out_valid), 64'h0);
        check_val("arst.in_ready", 64'(b32.in_ready), 64'h0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        armed = 1'b0;
        step(1'b1, 32'h66600013, 3'd0, 1'b1, 1'b0);
        step(1'b1, 32'h66600013, 3'd0, 1'b1, 1'b0);
        check_val("arst.first.valid", 64'(b32.out_valid), 64'h1);
        check_val("arst.first.ins", 64'(b32.out_ins), 64'h66600013);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_ins(), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
